// File: rtl/gate_bist_pkg.sv
// Shared definitions for the basic_gates BIST sequencer: state encoding,
// gate bit positions and the golden gate model.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int GATE_W = 6;
  localparam int NAND_B = 5;
  localparam int AND_B  = 4;
  localparam int OR_B   = 3;
  localparam int NOT_B  = 2;
  localparam int XOR_B  = 1;
  localparam int NOR_B  = 0;

  function automatic logic [GATE_W-1:0] golden(input logic a, input logic b);
    logic [GATE_W-1:0] g;
    g         = '0;
    g[NAND_B] = ~(a & b);
    g[AND_B]  = a & b;
    g[OR_B]   = a | b;
    g[NOT_B]  = ~a;
    g[XOR_B]  = a ^ b;
    g[NOR_B]  = ~(a | b);
    return g;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: sweeps {a,b} over all four vectors PASSES times, samples the
// six gate outputs after SETTLE_CYCLES and accumulates mismatch statistics.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              gate_a,
  output logic              gate_b,
  input  logic [GATE_W-1:0] gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [3:0]        fail_vec,
  output logic [GATE_W-1:0] fail_mask
);

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0]       PASS_LIM  = 4'(PASSES);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         pass_cnt_q, pass_cnt_d;
  logic [3:0]         settle_q, settle_d;
  logic               gate_a_q, gate_a_d;
  logic               gate_b_q, gate_b_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [3:0]         fail_vec_q, fail_vec_d;
  logic [GATE_W-1:0]  fail_mask_q, fail_mask_d;
  logic [GATE_W-1:0]  mismatch;
  logic               running;

  assign running  = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign mismatch = gate_out ^ golden(gate_a_q, gate_b_q);

  // NOTE: every _d gets its _q as a default first so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_cnt_d  = pass_cnt_q;
    settle_d    = settle_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          err_d                = '0;
          fail_vec_d           = '0;
          fail_mask_d          = '0;
          pass_d               = 1'b0;
          idx_d                = 2'd0;
          pass_cnt_d           = 4'd0;
          {gate_a_d, gate_b_d} = 2'b00;
          state_d              = ST_APPLY;
        end
      end
      ST_APPLY: begin
        settle_d = SETTLE_LD;
        state_d  = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q <= 4'd1) state_d = ST_CHECK;
        else                  settle_d = settle_q - 4'd1;
      end
      ST_CHECK: begin
        if (|mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          fail_vec_d[idx_q] = 1'b1;
          fail_mask_d       = fail_mask_q | mismatch;
        end
        idx_d   = idx_q + 2'd1;
        state_d = ST_APPLY;
        {gate_a_d, gate_b_d} = idx_d;
        if (idx_q == 2'd3) begin
          pass_cnt_d = pass_cnt_q + 4'd1;
          if (pass_cnt_d == PASS_LIM) begin
            state_d              = ST_DONE;
            pass_d               = (err_d == '0);
            {gate_a_d, gate_b_d} = 2'b00;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort keeps the partial statistics exactly as they stood before this cycle.
    if (abort && running) begin
      state_d              = ST_IDLE;
      pass_d               = 1'b0;
      {gate_a_d, gate_b_d} = 2'b00;
      err_d                = err_q;
      fail_vec_d           = fail_vec_q;
      fail_mask_d          = fail_mask_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop,
  // counters included, has an explicit reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      pass_cnt_q  <= 4'd0;
      settle_q    <= 4'd0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_vec_q  <= '0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_cnt_q  <= pass_cnt_d;
      settle_q    <= settle_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = running;
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: three instances cover the default
// configuration, a five-pass saturating run and a zero-settle run.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Independent gate model, {nand,and,or,not,xor,nor}.
  function automatic logic [5:0] model(input logic a, input logic b);
    return {~(a & b), a & b, a | b, ~a, a ^ b, ~(a | b)};
  endfunction

  // Instance 0: SETTLE=2, PASSES=1, with selectable gate fault.
  logic       start0, abort0, a0, b0, busy0, done0, pass0;
  logic [5:0] gout0, fm0;
  logic [3:0] err0, fv0;
  int         mode0;
  always_comb begin
    gout0 = model(a0, b0);
    if (mode0 == 1) gout0[1] = 1'b0;
  end
  gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .gate_a(a0), .gate_b(b0), .gate_out(gout0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_vec(fv0), .fail_mask(fm0));

  // Instance 5: SETTLE=2, PASSES=5, gate outputs always inverted.
  logic       start5, abort5, a5, b5, busy5, done5, pass5;
  logic [5:0] gout5, fm5;
  logic [3:0] err5, fv5;
  assign gout5 = ~model(a5, b5);
  gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(5), .ERR_W(4)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .abort(abort5),
    .gate_a(a5), .gate_b(b5), .gate_out(gout5), .busy(busy5), .done(done5),
    .pass(pass5), .err_count(err5), .fail_vec(fv5), .fail_mask(fm5));

  // Instance 6: SETTLE=0, PASSES=1, real gates.
  logic       start6, abort6, a6, b6, busy6, done6, pass6;
  logic [5:0] gout6, fm6;
  logic [3:0] err6, fv6;
  assign gout6 = model(a6, b6);
  gate_bist_ctrl #(.SETTLE_CYCLES(0), .PASSES(1), .ERR_W(4)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6),
    .gate_a(a6), .gate_b(b6), .gate_out(gout6), .busy(busy6), .done(done6),
    .pass(pass6), .err_count(err6), .fail_vec(fv6), .fail_mask(fm6));

  int done_cnt0 = 0;
  always @(posedge clk) if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_busy(input int sel);
    case (sel)
      5:       return busy5;
      6:       return busy6;
      default: return busy0;
    endcase
  endfunction

  function automatic logic sel_done(input int sel);
    case (sel)
      5:       return done5;
      6:       return done6;
      default: return done0;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      5:       start5 = v;
      6:       start6 = v;
      default: start0 = v;
    endcase
  endtask

  // Pulse start, then count cycles until done (cycle 1 = first cycle after start).
  task automatic run(input int sel, input int budget, output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    cyc = 1;
    if (sel_busy(sel)) bcyc++;
    while (!sel_done(sel) && cyc < budget) begin
      tick();
      cyc++;
      if (sel_busy(sel)) bcyc++;
    end
    if (!sel_done(sel)) cyc = -1;
  endtask

  int cyc, bcyc, dc;

  initial begin
    {start0, abort0, start5, abort5, start6, abort6} = '0;
    mode0 = 0;
    rst_n = 1'b0;
    repeat (3) tick();

    check("reset_outs0", {30'd0, a0, b0}, 32'd0);
    check("reset_stat0", {busy0, done0, pass0, err0, fv0, fm0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Real gates, default configuration.
    run(0, 100, cyc, bcyc);
    check("t1_latency", cyc, 32'd17);
    check("t1_busy_cycles", bcyc, 32'd16);
    check("t1_pass", pass0, 1'b1);
    check("t1_stats", {err0, fv0, fm0}, 32'd0);
    tick();
    check("t1_done_pulse", done0, 1'b0);

    // XOR stuck at 0.
    mode0 = 1;
    run(0, 100, cyc, bcyc);
    check("t2_latency", cyc, 32'd17);
    check("t2_err", err0, 4'd2);
    check("t2_fail_vec", fv0, 4'b0110);
    check("t2_fail_mask", fm0, 6'b000010);
    check("t2_pass", pass0, 1'b0);
    tick();
    mode0 = 0;

    // Inverted outputs over five passes: saturation.
    run(5, 300, cyc, bcyc);
    check("t3_latency", cyc, 32'd81);
    check("t3_err_sat", err5, 4'd15);
    check("t3_fail_vec", fv5, 4'hF);
    check("t3_fail_mask", fm5, 6'h3F);
    check("t3_pass", pass5, 1'b0);
    tick();

    // Abort during the third vector's settle window (cycle 10).
    dc = done_cnt0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (9) tick();
    check("t4_mid_gates", {a0, b0}, 2'b10);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("t4_abort_busy", busy0, 1'b0);
    check("t4_abort_gates", {a0, b0}, 2'b00);
    check("t4_abort_pass_done", {pass0, done0}, 2'b00);
    check("t4_abort_stats", {err0, fv0, fm0}, 32'd0);
    repeat (3) tick();
    check("t4_no_done", done_cnt0, dc);

    // Start and abort together in IDLE: no run.
    start0 = 1'b1;
    abort0 = 1'b1;
    tick();
    {start0, abort0} = 2'b00;
    check("t4_start_abort", busy0, 1'b0);

    run(0, 100, cyc, bcyc);
    check("t4_restart_latency", cyc, 32'd17);
    check("t4_restart_pass", pass0, 1'b1);
    tick();

    // Asynchronous reset mid-run, then start pulsed while busy.
    mode0 = 1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (15) tick();
    dc = done_cnt0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", {a0, b0, busy0, done0, pass0, err0, fv0, fm0}, 32'd0);
    tick();
    rst_n = 1'b1;
    mode0 = 0;
    tick();
    check("t5_no_done_on_reset", done_cnt0, dc);

    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (3) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 5;
    while (!done0 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t5_latency", cyc, 32'd17);
    repeat (4) tick();
    check("t5_done_count", done_cnt0 - dc, 32'd1);
    check("t5_idle_after", busy0, 1'b0);

    // Zero settle cycles.
    run(6, 100, cyc, bcyc);
    check("t6_latency", cyc, 32'd9);
    check("t6_busy_cycles", bcyc, 32'd8);
    check("t6_pass", pass6, 1'b1);
    check("t6_stats", {err6, fv6, fm6}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
